// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative MIPS multiply/divide unit that owns the HI/LO
//            registers. MULT/MULTU use shift-add and DIV/DIVU use restoring
//            shift-subtract, one bit per cycle. A signed operation runs on
//            the operand magnitudes, and the signs are applied in FIX.
// Ports    : CLK        - clock; all state updates on the rising edge
//            Reset      - synchronous active-high reset
//            Start      - launch an operation (sampled only in IDLE)
//            Op         - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//            Operand_A  - multiplicand / dividend
//            Operand_B  - multiplier / divisor
//            Write_HI   - MTHI strobe (honoured in IDLE without Start)
//            Write_LO   - MTLO strobe (honoured in IDLE without Start)
//            W_Data     - MTHI/MTLO data
//            Busy       - operation in progress
//            Done       - one-cycle pulse when HI/LO receive a result
//            Div_Zero   - pulses with Done for a divide by zero
//            HI, LO     - architectural HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] Operand_A,
   input  logic [WIDTH-1:0] Operand_B,
   input  logic             Write_HI,
   input  logic             Write_LO,
   input  logic [WIDTH-1:0] W_Data,
   output logic             Busy,
   output logic             Done,
   output logic             Div_Zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   logic [1:0]         state, state_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               is_div, is_div_nxt;
   logic               sign_a, sign_a_nxt;
   logic               sign_x, sign_x_nxt;     // sign(A) ^ sign(B)
   logic [WIDTH-1:0]   mag_a, mag_a_nxt;
   logic [WIDTH-1:0]   mag_b, mag_b_nxt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;
   logic               busy_nxt, done_nxt, div_zero_nxt;

   // Operand preparation at Start time
   logic             start_signed, start_neg_a, start_neg_b;
   logic [WIDTH-1:0] start_mag_a, start_mag_b;

   // Iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_step;

   // Result fix-up
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quot_fixed, rem_fixed, raw_a;

   always_comb begin
      start_signed = Op[0];
      start_neg_a  = start_signed & Operand_A[WIDTH-1];
      start_neg_b  = start_signed & Operand_B[WIDTH-1];
      start_mag_a  = start_neg_a ? (~Operand_A + 1'b1) : Operand_A;
      start_mag_b  = start_neg_b ? (~Operand_B + 1'b1) : Operand_B;
   end

   always_comb begin
      // Shift-add: add the multiplicand into the upper half when the LSB of
      // the product register is set, then shift right, keeping the carry.
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
      mul_step = {mul_sum, acc[WIDTH-1:1]};

      // Restoring divide: the shifted partial remainder needs WIDTH+1 bits;
      // bit WIDTH of the difference is the borrow.
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag_b};
      if (!div_trial[WIDTH])
         div_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         div_step = {acc[2*WIDTH-2:0], 1'b0};
   end

   always_comb begin
      prod_fixed = sign_x ? (~acc + 1'b1) : acc;
      quot_fixed = sign_x ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      rem_fixed  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      // Re-applying the sign to the magnitude gives back the captured dividend
      raw_a      = sign_a ? (~mag_a + 1'b1) : mag_a;
   end

   // State register
   always_ff @(posedge CLK) begin
      if (Reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (Start) state_nxt = ST_CALC;
         ST_CALC: if (count == LAST_COUNT) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      count_nxt    = count;
      is_div_nxt   = is_div;
      sign_a_nxt   = sign_a;
      sign_x_nxt   = sign_x;
      mag_a_nxt    = mag_a;
      mag_b_nxt    = mag_b;
      acc_nxt      = acc;
      hi_nxt       = HI;
      lo_nxt       = LO;
      busy_nxt     = (state_nxt != ST_IDLE);
      done_nxt     = 1'b0;
      div_zero_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start) begin
               is_div_nxt = Op[1];
               sign_a_nxt = start_neg_a;
               sign_x_nxt = start_neg_a ^ start_neg_b;
               mag_a_nxt  = start_mag_a;
               mag_b_nxt  = start_mag_b;
               acc_nxt    = {{WIDTH{1'b0}}, start_mag_a};
               count_nxt  = '0;
            end else begin
               if (Write_HI) hi_nxt = W_Data;
               if (Write_LO) lo_nxt = W_Data;
            end
         end
         ST_CALC: begin
            acc_nxt   = is_div ? div_step : mul_step;
            count_nxt = count + 1'b1;
         end
         ST_FIX: begin
            done_nxt = 1'b1;
            if (!is_div) begin
               hi_nxt = prod_fixed[2*WIDTH-1:WIDTH];
               lo_nxt = prod_fixed[WIDTH-1:0];
            end else if (mag_b == '0) begin
               hi_nxt       = raw_a;
               lo_nxt       = '1;
               div_zero_nxt = 1'b1;
            end else begin
               hi_nxt = rem_fixed;
               lo_nxt = quot_fixed;
            end
            count_nxt = '0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLK) begin
      if (Reset) begin
         count    <= '0;
         is_div   <= 1'b0;
         sign_a   <= 1'b0;
         sign_x   <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         acc      <= '0;
         HI       <= '0;
         LO       <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Div_Zero <= 1'b0;
      end else begin
         count    <= count_nxt;
         is_div   <= is_div_nxt;
         sign_a   <= sign_a_nxt;
         sign_x   <= sign_x_nxt;
         mag_a    <= mag_a_nxt;
         mag_b    <= mag_b_nxt;
         acc      <= acc_nxt;
         HI       <= hi_nxt;
         LO       <= lo_nxt;
         Busy     <= busy_nxt;
         Done     <= done_nxt;
         Div_Zero <= div_zero_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit. A table of directed
//            operations with hand-computed results, followed by sequences
//            for ignored Start/MTHI while busy, MTHI/MTLO, and mid-op reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

   localparam int WIDTH = 32;

   logic             CLK = 1'b0;
   logic             Reset;
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] Operand_A;
   logic [WIDTH-1:0] Operand_B;
   logic             Write_HI;
   logic             Write_LO;
   logic [WIDTH-1:0] W_Data;
   logic             Busy;
   logic             Done;
   logic             Div_Zero;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Start     (Start),
      .Op        (Op),
      .Operand_A (Operand_A),
      .Operand_B (Operand_B),
      .Write_HI  (Write_HI),
      .Write_LO  (Write_LO),
      .W_Data    (W_Data),
      .Busy      (Busy),
      .Done      (Done),
      .Div_Zero  (Div_Zero),
      .HI        (HI),
      .LO        (LO)
   );

   always #5 CLK = ~CLK;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[11];

   int checks   = 0;
   int failures = 0;

   // Expected architectural HI/LO contents
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Launch one operation and follow it through its whole latency.
   // inject>0: at that busy cycle, drive Start with new operands plus
   // Write_HI for one cycle (all must be ignored).
   // wr_with_start: assert Write_HI/Write_LO along with Start (dropped).
   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int inject, input logic wr_with_start);
      int bad_window;
      bad_window = 0;
      @(negedge CLK);
      Start     = 1'b1;
      Op        = op;
      Operand_A = a;
      Operand_B = b;
      if (wr_with_start) begin
         Write_HI = 1'b1;
         Write_LO = 1'b1;
         W_Data   = 32'hA5A5_A5A5;
      end
      tick;  // edge k
      Start    = 1'b0;
      Write_HI = 1'b0;
      Write_LO = 1'b0;
      check({name, " busy_after_start"}, {63'd0, Busy}, 64'd1);
      for (int i = 1; i <= 32; i++) begin
         Operand_A = $urandom;
         Operand_B = $urandom;
         Op        = 2'($urandom_range(0, 3));
         if (inject > 0 && i == inject) begin
            Start    = 1'b1;
            Write_HI = 1'b1;
            W_Data   = 32'hDEAD_BEEF;
         end else begin
            Start    = 1'b0;
            Write_HI = 1'b0;
         end
         tick;  // edge k+i
         if (Busy !== 1'b1 || Done !== 1'b0 || Div_Zero !== 1'b0 ||
             HI !== m_hi || LO !== m_lo)
            bad_window++;
      end
      Start    = 1'b0;
      Write_HI = 1'b0;
      check({name, " busy_window_errors"}, 64'(bad_window), 64'd0);
      tick;  // edge k+33
      check({name, " done"},     {63'd0, Done},     64'd1);
      check({name, " busy_off"}, {63'd0, Busy},     64'd0);
      check({name, " div_zero"}, {63'd0, Div_Zero}, {63'd0, edz});
      check({name, " hi"},       {32'd0, HI},       {32'd0, ehi});
      check({name, " lo"},       {32'd0, LO},       {32'd0, elo});
      m_hi = ehi;
      m_lo = elo;
      tick;
      check({name, " done_pulse_end"}, {62'd0, Done, Div_Zero}, 64'd0);
   endtask

   initial begin
      int stray_done;

      vecs[0]  = '{"multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1]  = '{"mult_m3_x_7",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[2]  = '{"mult_m3_x_m7",  OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0015, 1'b0};
      vecs[3]  = '{"div_m7_by_2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[4]  = '{"divu_100_by_7", OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[5]  = '{"divu_by_zero",  OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
      vecs[6]  = '{"div_overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[7]  = '{"div_7_by_m2",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[8]  = '{"div_m7_by_0",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{"mult_min_sq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[10] = '{"multu_2p16_sq", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

      Reset     = 1'b1;
      Start     = 1'b0;
      Op        = 2'b00;
      Operand_A = '0;
      Operand_B = '0;
      Write_HI  = 1'b0;
      Write_LO  = 1'b0;
      W_Data    = '0;
      m_hi      = '0;
      m_lo      = '0;
      tick;
      tick;
      @(negedge CLK);
      Reset = 1'b0;
      tick;
      check("reset_state", {HI, LO}, 64'd0);
      check("reset_flags", {61'd0, Busy, Done, Div_Zero}, 64'd0);

      for (int i = 0; i < 11; i++)
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dz, 0, 1'b0);

      // Start/MTHI asserted at busy cycle 5 must be ignored
      run_op("multu_ignore_busy", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002,
             32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 5, 1'b0);
      tick;
      check("idle_after_ignored_start", {63'd0, Busy}, 64'd0);

      // MTHI + MTLO together in IDLE
      @(negedge CLK);
      Write_HI = 1'b1;
      Write_LO = 1'b1;
      W_Data   = 32'h0000_1234;
      tick;
      Write_HI = 1'b0;
      Write_LO = 1'b0;
      check("mthi_mtlo_both", {HI, LO}, 64'h0000_1234_0000_1234);
      // MTLO alone
      @(negedge CLK);
      Write_LO = 1'b1;
      W_Data   = 32'h0000_5678;
      tick;
      Write_LO = 1'b0;
      check("mtlo_only", {HI, LO}, 64'h0000_1234_0000_5678);
      m_hi = 32'h0000_1234;
      m_lo = 32'h0000_5678;

      // Start together with write strobes: Start wins, writes dropped
      run_op("divu_start_wins", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 1'b1);

      // Mid-operation reset abandons the divide
      @(negedge CLK);
      Write_HI = 1'b1;
      Write_LO = 1'b1;
      W_Data   = 32'h0000_1234;
      tick;
      Write_HI = 1'b0;
      Write_LO = 1'b0;
      @(negedge CLK);
      Start     = 1'b1;
      Op        = OP_DIV;
      Operand_A = 32'hFFFF_FFF9;
      Operand_B = 32'h0000_0002;
      tick;
      Start = 1'b0;
      for (int i = 0; i < 9; i++) tick;
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      check("reset_mid_op_regs", {HI, LO}, 64'd0);
      check("reset_mid_op_flags", {61'd0, Busy, Done, Div_Zero}, 64'd0);
      m_hi = '0;
      m_lo = '0;
      stray_done = 0;
      for (int i = 0; i < 36; i++) begin
         tick;
         if (Done !== 1'b0 || Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            stray_done++;
      end
      check("no_result_after_reset", 64'(stray_done), 64'd0);
      run_op("div_after_reset", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
